gate_response_checker: RTL and testbench

Synchronous response checker for two-output, two-input gate blocks in the gate lab. It is the receiving end of the gate stimulus path: it accepts {A,B} stimulus and the DUT's {Y1,Y2} response one vector at a time and compares each response against a parameterised truth table. It accumulates vector, error and input-coverage statistics and issues a single pass/fail verdict, so gate benches and on-board tests can self-check instead of relying on printed output.

---
 rtl/gate_response_checker.sv | 139 +++++++++++++
 tb/tb_gate_response_checker.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_response_checker.sv
// Response checker for two-input, two-output gate blocks.
// Takes one {a,b} stimulus and {y1,y2} response per cycle, compares the
// response against parameterised truth tables and keeps vector, error and
// coverage statistics. A run ends with a pass/fail verdict in DONE.
module gate_response_checker #(
    parameter logic [3:0] EXP_Y1 = 4'b1000,  // expected y1, indexed by {a,b}
    parameter logic [3:0] EXP_Y2 = 4'b0111,  // expected y2, indexed by {a,b}
    parameter int         CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic             a,
    input  logic             b,
    input  logic             y1,
    input  logic             y2,
    output logic             busy,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [3:0]       covered,
    output logic [3:0]       first_fail,
    output logic             done,
    output logic             pass
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t state, state_next;

    // Stage S1: captured vector {a,b,y1,y2} and its last flag.
    logic       s1_valid;
    logic [3:0] s1_vec;
    logic       s1_last;
    logic       s1_mismatch;

    // Stage S2: compared vector, ready to update the statistics.
    logic       s2_valid;
    logic [3:0] s2_vec;
    logic       s2_last;
    logic       s2_mismatch;

    // A start in the same cycle always wins over an incoming vector.
    logic accept;
    assign accept = (state == RUN) && in_valid && !start;

    // Compare the S1 vector against the truth tables.
    assign s1_mismatch = (s1_vec[1] != EXP_Y1[s1_vec[3:2]]) |
                         (s1_vec[0] != EXP_Y2[s1_vec[3:2]]);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start restarts from anywhere, in_last ends the run.
    always_comb begin
        // NOTE: default first so no path leaves state_next unassigned (no latch).
        state_next = state;
        if (start) begin
            state_next = RUN;
        end else begin
            case (state)
                IDLE:  state_next = IDLE;
                RUN:   if (in_valid && in_last) state_next = DRAIN;
                DRAIN: if (s2_valid && s2_last) state_next = DONE;
                DONE:  state_next = DONE;
            endcase
        end
    end

    // Pipeline valid bits: cleared by reset and flushed by start.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
            s2_valid <= s1_valid && !start;
        end
    end

    // Pipeline payload: only ever consumed when the matching valid bit is set.
    always_ff @(posedge clk) begin
        // NOTE: payload registers are not reset; their valid bits gate every use.
        if (accept) begin
            s1_vec  <= {a, b, y1, y2};
            s1_last <= in_last;
        end
        if (s1_valid) begin
            s2_vec      <= s1_vec;
            s2_last     <= s1_last;
            s2_mismatch <= s1_mismatch;
        end
    end

    // Statistics: saturating counters, coverage bits and first failing vector.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            vec_cnt    <= '0;
            err_cnt    <= '0;
            covered    <= 4'h0;
            first_fail <= 4'h0;
        end else if (s2_valid) begin
            if (vec_cnt != CNT_MAX) begin
                vec_cnt <= vec_cnt + CNT_ONE;
            end
            covered[s2_vec[3:2]] <= 1'b1;
            if (s2_mismatch) begin
                if (err_cnt != CNT_MAX) begin
                    err_cnt <= err_cnt + CNT_ONE;
                end
                if (err_cnt == '0) begin
                    first_fail <= s2_vec;
                end
            end
        end
    end

    // Status outputs decode registered state only.
    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);
    assign pass = (state == DONE) && (err_cnt == '0) && (covered == 4'hF);

endmodule

// File: tb/tb_gate_response_checker.sv
// Bench for gate_response_checker: directed scenarios plus random runs,
// compared against a run-level model of the AND/NAND check rules. A second
// instance with 2-bit counters shares the stimulus to exercise saturation.
module tb_gate_response_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;
    logic a = 1'b0, b = 1'b0, y1 = 1'b0, y2 = 1'b0;

    logic       busy, done, pass;
    logic [7:0] vec_cnt, err_cnt;
    logic [3:0] covered, first_fail;

    logic       busy_s, done_s, pass_s;
    logic [1:0] vec_cnt_s, err_cnt_s;
    logic [3:0] covered_s, first_fail_s;

    int checks = 0;
    int errors = 0;

    // Run-level model state.
    int         m_vec;
    int         m_err;
    logic [3:0] m_cov;
    logic [3:0] m_ff;

    always #5 clk = ~clk;

    gate_response_checker dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_last(in_last),
        .a(a), .b(b), .y1(y1), .y2(y2),
        .busy(busy), .vec_cnt(vec_cnt), .err_cnt(err_cnt), .covered(covered),
        .first_fail(first_fail), .done(done), .pass(pass)
    );

    gate_response_checker #(.CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_last(in_last),
        .a(a), .b(b), .y1(y1), .y2(y2),
        .busy(busy_s), .vec_cnt(vec_cnt_s), .err_cnt(err_cnt_s), .covered(covered_s),
        .first_fail(first_fail_s), .done(done_s), .pass(pass_s)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic int sat(input int v, input int w);
        int m;
        m = (1 << w) - 1;
        return (v > m) ? m : v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_vec = 0;
        m_err = 0;
        m_cov = 4'h0;
        m_ff  = 4'h0;
    endtask

    // The gate under test should behave as AND on y1 and NAND on y2.
    task automatic model_add(input logic va, input logic vb, input logic vy1, input logic vy2);
        logic good;
        good = (vy1 == (va & vb)) && (vy2 == !(va & vb));
        m_vec++;
        m_cov[{va, vb}] = 1'b1;
        if (!good) begin
            if (m_err == 0) m_ff = {va, vb, vy1, vy2};
            m_err++;
        end
    endtask

    // Present one vector for one cycle without recording it in the model.
    task automatic drive(input logic va, input logic vb, input logic vy1, input logic vy2, input logic vlast);
        a = va; b = vb; y1 = vy1; y2 = vy2;
        in_last  = vlast;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send(input logic va, input logic vb, input logic vy1, input logic vy2, input logic vlast);
        model_add(va, vb, vy1, vy2);
        drive(va, vb, vy1, vy2, vlast);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        model_clear();
    endtask

    // Compare both instances against the model once a run is done.
    task automatic check_stats(input string tag);
        logic exp_pass;
        exp_pass = (m_err == 0) && (m_cov == 4'hF);
        check({tag, "/done"},   done,       1);
        check({tag, "/vec"},    vec_cnt,    sat(m_vec, 8));
        check({tag, "/err"},    err_cnt,    sat(m_err, 8));
        check({tag, "/cov"},    covered,    m_cov);
        check({tag, "/ff"},     first_fail, m_ff);
        check({tag, "/pass"},   pass,       exp_pass);
        check({tag, "/done_s"}, done_s,     1);
        check({tag, "/vec_s"},  vec_cnt_s,  sat(m_vec, 2));
        check({tag, "/err_s"},  err_cnt_s,  sat(m_err, 2));
        check({tag, "/ff_s"},   first_fail_s, m_ff);
        check({tag, "/pass_s"}, pass_s,     exp_pass);
    endtask

    // Called right after the in_last vector is accepted; waits for done
    // with a bounded budget, optionally throwing ignored junk at the inputs.
    task automatic finish_run(input string tag, input bit junk);
        int cyc;
        cyc = 0;
        check({tag, "/drain_busy"}, busy, 1);
        check({tag, "/drain_done"}, done, 0);
        while (done !== 1'b1 && cyc < 20) begin
            if (junk) begin
                in_valid = 1'($urandom);
                in_last  = 1'($urandom);
                a = 1'($urandom); b = 1'($urandom); y1 = 1'($urandom); y2 = 1'($urandom);
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check({tag, "/latency"}, cyc, 2);
        check_stats(tag);
    endtask

    initial begin
        // Reset state.
        tick();
        tick();
        rst = 1'b0;
        check("reset/busy", busy, 0);
        check("reset/done", done, 0);
        check("reset/pass", pass, 0);
        check("reset/vec",  vec_cnt, 0);
        check("reset/err",  err_cnt, 0);
        check("reset/cov",  covered, 0);
        check("reset/ff",   first_fail, 0);

        // Vectors in IDLE are ignored.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        tick();
        tick();
        check("idle/vec", vec_cnt, 0);
        check("idle/busy", busy, 0);

        // Correct AND/NAND run.
        do_start();
        check("start/busy", busy, 1);
        check("start/done", done, 0);
        check("start/vec",  vec_cnt, 0);
        send(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        send(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        send(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        finish_run("good", 1'b0);

        // Held in DONE while inputs wiggle.
        repeat (3) drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        check("hold/vec", vec_cnt, 4);
        check("hold/pass", pass, 1);

        // Faulty DUT.
        do_start();
        check("restart/vec", vec_cnt, 0);
        check("restart/cov", covered, 0);
        send(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        send(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        send(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check("faulty/model_ff", m_ff, 4'b0111);
        finish_run("faulty", 1'b0);

        // Incomplete coverage.
        do_start();
        send(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        finish_run("partial", 1'b0);

        // Restart mid-run; the vector presented with start is dropped.
        do_start();
        send(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        send(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        start = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        start = 1'b0;
        model_clear();
        tick();
        tick();
        check("midstart/vec", vec_cnt, 0);
        check("midstart/err", err_cnt, 0);
        send(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        send(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        send(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        finish_run("midstart", 1'b0);

        // Reset one cycle after in_last.
        do_start();
        send(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        send(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstdrain/busy", busy, 0);
        check("rstdrain/done", done, 0);
        check("rstdrain/pass", pass, 0);
        check("rstdrain/vec",  vec_cnt, 0);
        check("rstdrain/cov",  covered, 0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        tick();
        check("rstdrain/vec_after", vec_cnt, 0);
        check("rstdrain/err_after", err_cnt, 0);
        check("rstdrain/cov_after", covered, 0);
        check("rstdrain/done_after", done, 0);

        // Saturation: five failing vectors (2-bit instance pins at 3).
        do_start();
        for (int i = 0; i < 5; i++) begin
            logic va, vb;
            va = 1'($urandom);
            vb = 1'($urandom);
            send(va, vb, !(va & vb), (va & vb), i == 4);
        end
        finish_run("sat", 1'b0);
        check("sat/vec_s_pinned", vec_cnt_s, 3);
        check("sat/err_s_pinned", err_cnt_s, 3);

        // Random runs with gaps, junk during DRAIN/DONE and varied faults.
        for (int r = 0; r < 25; r++) begin
            int n;
            do_start();
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) begin
                logic va, vb, e1, e2;
                int kind;
                repeat ($urandom_range(0, 2)) tick();
                va = 1'($urandom);
                vb = 1'($urandom);
                e1 = va & vb;
                e2 = !(va & vb);
                kind = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 3) : 0;
                send(va, vb, e1 ^ kind[1], e2 ^ kind[0], i == n - 1);
            end
            finish_run($sformatf("rand%0d", r), 1'b1);
            repeat (2) drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
            check($sformatf("rand%0d/held", r), vec_cnt, sat(m_vec, 8));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
